uart_rx_oversample: RTL and testbench



---
 rtl/uart_rx_oversample.sv | 228 ++++++++++++++++++++++
 tb/tb_uart_rx_oversample.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver: start-bit glitch rejection, optional parity,
// framing/break detection and a first-word-fall-through receive FIFO.
module uart_rx_oversample #(
    parameter int unsigned clk_freq   = 1000000,
    parameter int unsigned baud_rate  = 9600,
    parameter int unsigned OVS        = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    input  logic                          rd_en,
    input  logic                          clr_ovr,
    output logic [7:0]                    dout,
    output logic                          dout_ferr,
    output logic                          dout_perr,
    output logic                          valid,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overrun,
    output logic                          busy
);

    localparam int unsigned DIV = clk_freq / (baud_rate * OVS);
    localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SW  = $clog2(OVS);
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned LW  = AW + 1;

    typedef struct packed {
        logic       perr;
        logic       ferr;
        logic [7:0] data;
    } frame_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    // Two-flop synchroniser, idles high so reset does not look like a start bit
    logic rx_m, rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Oversample tick generator
    logic [TW-1:0] tcnt;
    logic          tick;

    assign tick = (tcnt == TW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst)       tcnt <= '0;
        else if (tick) tcnt <= '0;
        else           tcnt <= tcnt + TW'(1);
    end

    // Receive FSM state
    state_t        state, state_d;
    logic [SW-1:0] scnt, scnt_d;
    logic [2:0]    bcnt, bcnt_d;
    logic [7:0]    shreg, shreg_d;
    logic          perr, perr_d;
    logic          push_q, push_d;
    frame_t        word_q, word_d;
    logic          bit_end, half_end;

    assign bit_end  = (scnt == SW'(OVS - 1));
    assign half_end = (scnt == SW'(OVS / 2 - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            scnt   <= '0;
            bcnt   <= '0;
            shreg  <= '0;
            perr   <= 1'b0;
            push_q <= 1'b0;
            word_q <= '0;
            busy   <= 1'b0;
        end else begin
            state  <= state_d;
            scnt   <= scnt_d;
            bcnt   <= bcnt_d;
            shreg  <= shreg_d;
            perr   <= perr_d;
            push_q <= push_d;
            word_q <= word_d;
            busy   <= (state_d != S_IDLE);
        end
    end

    always_comb begin
        state_d = state;
        scnt_d  = scnt;
        bcnt_d  = bcnt;
        shreg_d = shreg;
        perr_d  = perr;
        push_d  = 1'b0;
        word_d  = word_q;

        if (tick) begin
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_d = S_START;
                        scnt_d  = '0;
                    end
                end
                S_START: begin
                    if (half_end) begin
                        // Line must still be low mid start bit, else it was a glitch
                        if (!rx_s) begin
                            state_d = S_DATA;
                            scnt_d  = '0;
                            bcnt_d  = '0;
                            perr_d  = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        scnt_d = scnt + SW'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        shreg_d = {rx_s, shreg[7:1]};
                        scnt_d  = '0;
                        bcnt_d  = bcnt + 3'd1;
                        if (bcnt == 3'd7) begin
                            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end
                    end else begin
                        scnt_d = scnt + SW'(1);
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        perr_d  = (^shreg) ^ rx_s ^ 1'(PARITY_ODD);
                        scnt_d  = '0;
                        state_d = S_STOP;
                    end else begin
                        scnt_d = scnt + SW'(1);
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        push_d      = 1'b1;
                        word_d.perr = perr;
                        word_d.ferr = ~rx_s;
                        word_d.data = shreg;
                        scnt_d      = '0;
                        state_d     = rx_s ? S_IDLE : S_BREAK;
                    end else begin
                        scnt_d = scnt + SW'(1);
                    end
                end
                S_BREAK: begin
                    // Held-low line: wait for idle so only one ferr entry results
                    if (rx_s) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Receive FIFO
    frame_t        mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] count, count_d;
    logic          full, do_push, do_pop, ovr_set;
    frame_t        head;

    assign full    = (count == LW'(FIFO_DEPTH));
    assign do_pop  = rd_en & valid;
    assign do_push = push_q & (~full | do_pop);
    assign ovr_set = push_q & full & ~do_pop;

    always_comb begin
        count_d = count;
        case ({do_push, do_pop})
            2'b10:   count_d = count + LW'(1);
            2'b01:   count_d = count - LW'(1);
            default: count_d = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= word_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count   <= count_d;
            valid   <= (count_d != '0);
            // Set has priority over a simultaneous clear
            overrun <= ovr_set | (overrun & ~clr_ovr);
        end
    end

    assign head      = mem[rd_ptr];
    assign level     = count;
    assign dout      = valid ? head.data : 8'h00;
    assign dout_ferr = valid & head.ferr;
    assign dout_perr = valid & head.perr;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Self-checking bench for uart_rx_oversample: default instance plus an
// odd-parity instance, driven at 104 clk per bit and checked via scoreboards.
`timescale 1ns/1ps
module tb_uart_rx_oversample;

    localparam int BIT   = 104;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    logic rx0, rd0, clr0;
    logic rx1, rd1, clr1;
    logic [7:0] dout0, dout1;
    logic ferr0, perr0, valid0, ovr0, busy0;
    logic ferr1, perr1, valid1, ovr1, busy1;
    logic [2:0] level0, level1;

    always #5 clk = ~clk;

    uart_rx_oversample u_dut0 (
        .clk(clk), .rst(rst), .rx(rx0), .rd_en(rd0), .clr_ovr(clr0),
        .dout(dout0), .dout_ferr(ferr0), .dout_perr(perr0), .valid(valid0),
        .level(level0), .overrun(ovr0), .busy(busy0)
    );

    uart_rx_oversample #(.PARITY_EN(1), .PARITY_ODD(1)) u_dut1 (
        .clk(clk), .rst(rst), .rx(rx1), .rd_en(rd1), .clr_ovr(clr1),
        .dout(dout1), .dout_ferr(ferr1), .dout_perr(perr1), .valid(valid1),
        .level(level1), .overrun(ovr1), .busy(busy1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] q0[$];
    logic [9:0] q1[$];
    logic       ovr_exp0 = 1'b0;
    logic       ovr_exp1 = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_rx(input int which, input logic v);
        if (which == 0) rx0 = v;
        else            rx1 = v;
    endtask

    task automatic send_frame(input int which, input logic [7:0] d, input logic pbit,
                              input int stop_low);
        logic [9:0] exp;
        exp[7:0] = d;
        exp[8]   = (stop_low > 0);
        exp[9]   = (which == 1) ? ((^d) ^ pbit ^ 1'b1) : 1'b0;
        if (which == 0) begin
            if (q0.size() < DEPTH) q0.push_back(exp);
            else                   ovr_exp0 = 1'b1;
        end else begin
            if (q1.size() < DEPTH) q1.push_back(exp);
            else                   ovr_exp1 = 1'b1;
        end
        @(negedge clk);
        set_rx(which, 1'b0);
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_rx(which, d[i]);
            repeat (BIT) @(negedge clk);
        end
        if (which == 1) begin
            set_rx(which, pbit);
            repeat (BIT) @(negedge clk);
        end
        if (stop_low > 0) begin
            set_rx(which, 1'b0);
            repeat (stop_low * BIT) @(negedge clk);
        end
        set_rx(which, 1'b1);
        repeat (BIT + 20) @(negedge clk);
    endtask

    task automatic pop_check(input int which, input string tag);
        logic [9:0] exp;
        logic [9:0] got;
        logic       v;
        v = 1'b0;
        for (int i = 0; i < 300; i++) begin
            v = (which == 0) ? valid0 : valid1;
            if (v) break;
            @(negedge clk);
        end
        check({tag, "_valid"}, 32'(v), 32'd1);
        if (!v) return;
        if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
            check({tag, "_unexpected"}, 32'(v), 32'd0);
            return;
        end
        exp = (which == 0) ? q0.pop_front() : q1.pop_front();
        got = (which == 0) ? {perr0, ferr0, dout0} : {perr1, ferr1, dout1};
        check({tag, "_data"}, 32'(got[7:0]), 32'(exp[7:0]));
        check({tag, "_ferr"}, 32'(got[8]),   32'(exp[8]));
        check({tag, "_perr"}, 32'(got[9]),   32'(exp[9]));
        if (which == 0) rd0 = 1'b1;
        else            rd1 = 1'b1;
        @(negedge clk);
        rd0 = 1'b0;
        rd1 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rx0 = 1'b1; rd0 = 1'b0; clr0 = 1'b0;
        rx1 = 1'b1; rd1 = 1'b0; clr1 = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_valid0", 32'(valid0), 32'd0);
        check("rst_level0", 32'(level0), 32'd0);
        check("rst_ovr0",   32'(ovr0),   32'd0);
        check("rst_busy0",  32'(busy0),  32'd0);
        check("rst_dout0",  32'(dout0),  32'd0);
        check("rst_valid1", 32'(valid1), 32'd0);
        check("rst_busy1",  32'(busy1),  32'd0);
        check("rst_ovr1",   32'(ovr1),   32'd0);

        // Single frame
        send_frame(0, 8'hA5, 1'b0, 0);
        check("a5_level", 32'(level0), 32'd1);
        check("a5_valid", 32'(valid0), 32'd1);
        pop_check(0, "a5");
        check("a5_valid_after", 32'(valid0), 32'd0);
        check("a5_dout_after",  32'(dout0),  32'd0);
        check("a5_level_after", 32'(level0), 32'd0);

        // Start-bit glitch
        @(negedge clk);
        rx0 = 1'b0;
        repeat (20) @(negedge clk);
        rx0 = 1'b1;
        for (int i = 0; i < 90; i++) begin
            if (!busy0) break;
            @(negedge clk);
        end
        check("glitch_busy", 32'(busy0), 32'd0);
        repeat (2 * BIT) @(negedge clk);
        check("glitch_level", 32'(level0), 32'd0);

        // Odd parity: good then bad
        send_frame(1, 8'h03, 1'b1, 0);
        send_frame(1, 8'h03, 1'b0, 0);
        check("par_level", 32'(level1), 32'd2);
        pop_check(1, "par_ok");
        pop_check(1, "par_bad");

        // Held-low stop bit then normal frame
        send_frame(0, 8'h55, 1'b0, 3);
        send_frame(0, 8'h12, 1'b0, 0);
        check("brk_level", 32'(level0), 32'd2);
        pop_check(0, "brk_55");
        pop_check(0, "brk_12");

        // Overrun
        for (int k = 1; k <= 5; k++) send_frame(0, 8'(k), 1'b0, 0);
        check("ovr_level", 32'(level0), 32'd4);
        check("ovr_set",   32'(ovr0),   32'(ovr_exp0));
        for (int k = 0; k < 4; k++) pop_check(0, "ovr_pop");
        @(negedge clk);
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        ovr_exp0 = 1'b0;
        @(negedge clk);
        check("ovr_clr", 32'(ovr0), 32'(ovr_exp0));

        // Overrun set while clr_ovr is held: set must win
        for (int k = 6; k <= 9; k++) send_frame(0, 8'(k), 1'b0, 0);
        fork
            send_frame(0, 8'h0A, 1'b0, 0);
            begin
                clr0 = 1'b1;
                for (int i = 0; i < 2000; i++) begin
                    @(negedge clk);
                    if (ovr0) break;
                end
                clr0 = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        check("ovr_vs_clr", 32'(ovr0), 32'(ovr_exp0));
        for (int k = 0; k < 4; k++) pop_check(0, "ovr2_pop");

        // Reset during data bit 4
        @(negedge clk);
        rx0 = 1'b0;
        repeat (BIT) @(negedge clk);
        repeat (4 * BIT + BIT / 2) @(negedge clk);
        rst = 1'b1;
        rx0 = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        ovr_exp0 = 1'b0;
        @(negedge clk);
        check("mid_rst_busy",  32'(busy0),  32'd0);
        check("mid_rst_level", 32'(level0), 32'd0);
        check("mid_rst_ovr",   32'(ovr0),   32'(ovr_exp0));
        repeat (2 * BIT) @(negedge clk);
        check("mid_rst_nopush", 32'(level0), 32'd0);
        send_frame(0, 8'h3C, 1'b0, 0);
        check("mid_rst_level1", 32'(level0), 32'd1);
        pop_check(0, "mid_rst_3c");

        repeat (10) @(negedge clk);
        check("end_valid0", 32'(valid0), 32'd0);
        check("end_valid1", 32'(valid1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
